// File: rtl/pixel_renderer.sv
// Procedural disc shader: three-stage pipeline from (hcount, vcount) to RGB.
// Optional checkerboard background is enabled by defining RENDERER_CHECKER_EN.
module pixel_renderer #(
  parameter int WIDTH       = 300,
  parameter int HEIGHT      = 300,
  parameter int RADIUS      = 100,
  parameter int SHADE_SHIFT = 6
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  input  logic [32:0] hcount_in,
  input  logic [32:0] vcount_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out
);

  localparam int CW = 18;
  localparam int DW = 36;

  localparam logic [32:0]          WIDTH_U  = 33'(WIDTH);
  localparam logic [32:0]          HEIGHT_U = 33'(HEIGHT);
  localparam logic signed [CW-1:0] CX       = CW'(WIDTH / 2);
  localparam logic signed [CW-1:0] CY       = CW'(HEIGHT / 2);
  localparam logic [DW-1:0]        R2       = DW'(RADIUS) * DW'(RADIUS);

  // Only the low bits feed the offset; off-screen pixels are masked later.
  function automatic logic signed [CW-1:0] offset(input logic [32:0] c,
                                                  input logic signed [CW-1:0] ctr);
    return $signed({1'b0, c[CW-2:0]}) - ctr;
  endfunction

  function automatic logic [7:0] sat_shade(input logic [DW-1:0] d2);
    logic [DW-1:0] s;
    s = d2 >> SHADE_SHIFT;
    return (s > DW'(255)) ? 8'hff : s[7:0];
  endfunction

  // ---- S1: on-screen flag and signed offsets from the centre
  logic                 vld_p0;
  logic                 on_p0;
  logic signed [CW-1:0] dx_p0;
  logic signed [CW-1:0] dy_p0;

  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_p0 <= 1'b0;
      on_p0  <= 1'b0;
      dx_p0  <= '0;
      dy_p0  <= '0;
    end else begin
      vld_p0 <= 1'b1;
      on_p0  <= (hcount_in < WIDTH_U) && (vcount_in < HEIGHT_U);
      dx_p0  <= offset(hcount_in, CX);
      dy_p0  <= offset(vcount_in, CY);
    end
  end

`ifdef RENDERER_CHECKER_EN
  logic chk_p0;
  logic chk_p1;

  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      chk_p0 <= 1'b0;
      chk_p1 <= 1'b0;
    end else begin
      chk_p0 <= hcount_in[5] ^ vcount_in[5];
      chk_p1 <= chk_p0;
    end
  end
`endif

  logic signed [DW-1:0] dx_w;
  logic signed [DW-1:0] dy_w;
  logic signed [DW-1:0] dx_sq;
  logic signed [DW-1:0] dy_sq;
  logic        [DW-1:0] d2_c;

  assign dx_w  = DW'(dx_p0);
  assign dy_w  = DW'(dy_p0);
  assign dx_sq = dx_w * dx_w;
  assign dy_sq = dy_w * dy_w;
  assign d2_c  = $unsigned(dx_sq) + $unsigned(dy_sq);

  // ---- S2: squared distance
  logic          vld_p1;
  logic          on_p1;
  logic [DW-1:0] d2_p1;

  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_p1 <= 1'b0;
      on_p1  <= 1'b0;
      d2_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      on_p1  <= on_p0;
      d2_p1  <= d2_c;
    end
  end

  logic [7:0]  bg_c;
  logic [7:0]  shade_c;
  logic [23:0] rgb_c;

`ifdef RENDERER_CHECKER_EN
  assign bg_c = chk_p1 ? 8'h40 : 8'h20;
`else
  assign bg_c = 8'h00;
`endif

  always_comb begin
    shade_c = 8'hff - sat_shade(d2_p1);
    rgb_c   = '0;
    if (vld_p1 && on_p1) begin
      if (d2_p1 < R2) rgb_c = {8'h00, shade_c, shade_c >> 1};
      else            rgb_c = {3{bg_c}};
    end
  end

  // ---- S3: registered RGB
  logic [7:0] red_p2;
  logic [7:0] green_p2;
  logic [7:0] blue_p2;

  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      red_p2   <= '0;
      green_p2 <= '0;
      blue_p2  <= '0;
    end else begin
      red_p2   <= rgb_c[23:16];
      green_p2 <= rgb_c[15:8];
      blue_p2  <= rgb_c[7:0];
    end
  end

  assign red_out   = red_p2;
  assign green_out = green_p2;
  assign blue_out  = blue_p2;

endmodule

// File: tb/tb_pixel_renderer.sv
// Scoreboard bench for pixel_renderer: directed pixels, a diagonal sweep and resets.
module tb_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [32:0] h = '0;
  logic [32:0] v = '0;
  logic [7:0]  r, g, b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic [32:0] h;
    logic [32:0] v;
  } exp_t;

  exp_t q[$];

`ifdef RENDERER_CHECKER_EN
  localparam logic [23:0] BG_LO = 24'h202020;
  localparam logic [23:0] BG_HI = 24'h404040;
`else
  localparam logic [23:0] BG_LO = 24'h000000;
  localparam logic [23:0] BG_HI = 24'h000000;
`endif

  pixel_renderer #(
    .WIDTH(300), .HEIGHT(300), .RADIUS(100), .SHADE_SHIFT(6)
  ) dut (
    .clk_pixel_in(clk),
    .rst_in      (rst_n),
    .hcount_in   (h),
    .vcount_in   (v),
    .red_out     (r),
    .green_out   (g),
    .blue_out    (b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [23:0] model(input int x, input int y);
    longint dx, dy, d2, s;
    logic [7:0] gg, bgv;
    if (x >= 300 || y >= 300) return 24'h0;
`ifdef RENDERER_CHECKER_EN
    bgv = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 8'h40 : 8'h20;
`else
    bgv = 8'h00;
`endif
    dx = x - 150;
    dy = y - 150;
    d2 = dx * dx + dy * dy;
    if (d2 >= 10000) return {3{bgv}};
    s = d2 / 64;
    if (s > 255) s = 255;
    gg = 8'(255 - s);
    return {8'h00, gg, gg >> 1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int due, input logic [23:0] e, input logic [32:0] hh,
                      input logic [32:0] vv);
    exp_t x;
    x.due = due;
    x.rgb = e;
    x.h   = hh;
    x.v   = vv;
    q.push_back(x);
  endtask

  task automatic drive(input logic [32:0] hh, input logic [32:0] vv, input logic [23:0] e);
    h = hh;
    v = vv;
    push(cyc + 3, e, hh, vv);
  endtask

  task automatic check_now(input string nm);
    checks++;
    if ({r, g, b} !== 24'h0) begin
      failures++;
      $display("FAIL %s got=%h expected=000000", nm, {r, g, b});
    end
  endtask

  // Monitor: compare each expected pixel on the cycle it is due.
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      if (q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({r, g, b} !== e.rgb) begin
          failures++;
          $display("FAIL pixel h=%0d v=%0d got=%h expected=%h", e.h, e.v, {r, g, b}, e.rgb);
        end
      end else if (q[0].due < cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed h=%0d v=%0d due=%0d now=%0d", e.h, e.v, e.due, cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    h = 33'd150;
    v = 33'd100;
    #1 check_now("reset_async");
    repeat (3) @(posedge clk);
    #1 check_now("reset_hold");

    tick();
    rst_n = 1'b1;
    push(cyc + 1, 24'h0, 33'd150, 33'd150);
    push(cyc + 2, 24'h0, 33'd150, 33'd150);
    drive(33'd150, 33'd150, 24'h00ff7f);

    tick(); drive(33'd150, 33'd100, 24'h00d86c);
    tick(); drive(33'd249, 33'd150, 24'h006633);
    tick(); drive(33'd250, 33'd150, BG_HI);
    tick(); drive(33'd10,  33'd10,  BG_LO);
    tick(); drive(33'd40,  33'd10,  BG_HI);
    tick(); drive(33'd0,   33'd300, 24'h0);
    tick(); drive(33'd300, 33'd0,   24'h0);
    tick(); drive(33'h1_0000_0000, 33'd5, 24'h0);
    tick(); drive(33'd299, 33'd299, BG_LO);

    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 90) begin
        rst_n = 1'b0;
        #1 check_now("reset_midstream");
        q.delete();
        tick();
        rst_n = 1'b1;
        push(cyc + 1, 24'h0, 33'(i), 33'(300 - i));
        push(cyc + 2, 24'h0, 33'(i), 33'(300 - i));
      end
      drive(33'(i), 33'(300 - i), model(i, 300 - i));
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
